// File: rtl/msrv32_imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry output FIFO.
// The immediate type comes from imm_type_in or from the opcode. Each entry stores {imm, type, illegal}.
module msrv32_imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b0
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic            flush_in,
    input  logic            in_valid_in,
    output logic            in_ready_out,
    input  logic [31:0]     instr_in,
    input  logic [2:0]      imm_type_in,
    output logic            out_valid_out,
    input  logic            out_ready_in,
    output logic [XLEN-1:0] imm_out,
    output logic [2:0]      imm_type_out,
    output logic            illegal_out
);
    localparam logic [2:0] TYPE_I    = 3'b000;
    localparam logic [2:0] TYPE_I_LD = 3'b001;
    localparam logic [2:0] TYPE_S    = 3'b010;
    localparam logic [2:0] TYPE_B    = 3'b011;
    localparam logic [2:0] TYPE_U    = 3'b100;
    localparam logic [2:0] TYPE_J    = 3'b101;
    localparam logic [2:0] TYPE_ZIMM = 3'b110;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            illegal;
    } entry_t;

    logic [2:0]         typ_res;
    logic               illegal_res;
    logic signed [31:0] imm32;
    entry_t             entry_in;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        typ_res     = imm_type_in;
        illegal_res = 1'b0;
        if (AUTO_DECODE) begin
            case (instr_in[6:0])
                7'b0010011:             typ_res = TYPE_I;
                7'b0000011, 7'b1100111: typ_res = TYPE_I_LD;
                7'b0100011:             typ_res = TYPE_S;
                7'b1100011:             typ_res = TYPE_B;
                7'b0110111, 7'b0010111: typ_res = TYPE_U;
                7'b1101111:             typ_res = TYPE_J;
                7'b1110011:             typ_res = instr_in[14] ? TYPE_ZIMM : TYPE_I;
                default: begin
                    typ_res     = TYPE_I;
                    illegal_res = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
        case (typ_res)
            TYPE_S:    imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            TYPE_B:    imm32 = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
            TYPE_U:    imm32 = {instr_in[31:12], 12'h000};
            TYPE_J:    imm32 = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
            TYPE_ZIMM: imm32 = {27'd0, instr_in[19:15]};
            default:   imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
        endcase
        if (illegal_res) imm32 = '0;
    end

    // The signed cast widens imm32[31] up to XLEN-1. zimm has bit 31 clear, so it stays zero-extended.
    assign entry_in = '{imm: XLEN'(imm32), typ: typ_res, illegal: illegal_res};

    entry_t     mem [2];
    entry_t     head;
    logic [1:0] count;
    logic       wr_ptr, rd_ptr, last_ptr, primed;
    logic       push, pop;

    assign in_ready_out  = (count < 2'd2);
    assign out_valid_out = (count != 2'd0);
    assign push          = in_valid_in && in_ready_out;
    assign pop           = out_valid_out && out_ready_in;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            last_ptr <= 1'b0;
            primed   <= 1'b0;
        end else begin
            // last_ptr remembers the most recent head, so it can be replayed while the FIFO is empty.
            if (count != 2'd0) last_ptr <= rd_ptr;
            if (flush_in) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                    primed <= 1'b1;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset. Outputs are masked by primed until the first entry is written.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push && !flush_in) mem[wr_ptr] <= entry_in;
    end

    assign head         = mem[(count == 2'd0) ? last_ptr : rd_ptr];
    assign imm_out      = primed ? head.imm     : '0;
    assign imm_type_out = primed ? head.typ     : 3'b000;
    assign illegal_out  = primed ? head.illegal : 1'b0;

endmodule

// File: tb/tb_msrv32_imm_gen_pipe.sv
// Directed bench for msrv32_imm_gen_pipe: decode formats on three configurations, FIFO flow control, flush and reset.
module tb_msrv32_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  imm_type = '0;

    logic        rdy_a, vld_a, ill_a;
    logic [31:0] imm_a;
    logic [2:0]  typ_a;
    logic        rdy_w, vld_w, ill_w;
    logic [63:0] imm_w;
    logic [2:0]  typ_w;
    logic        rdy_d, vld_d, ill_d;
    logic [31:0] imm_d;
    logic [2:0]  typ_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msrv32_imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(rdy_a), .instr_in(instr), .imm_type_in(imm_type),
        .out_valid_out(vld_a), .out_ready_in(out_ready), .imm_out(imm_a),
        .imm_type_out(typ_a), .illegal_out(ill_a));

    msrv32_imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0)) dut64 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(rdy_w), .instr_in(instr), .imm_type_in(imm_type),
        .out_valid_out(vld_w), .out_ready_in(out_ready), .imm_out(imm_w),
        .imm_type_out(typ_w), .illegal_out(ill_w));

    msrv32_imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) dut_ad (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n), .flush_in(flush),
        .in_valid_in(in_valid), .in_ready_out(rdy_d), .instr_in(instr), .imm_type_in(imm_type),
        .out_valid_out(vld_d), .out_ready_in(out_ready), .imm_out(imm_d),
        .imm_type_out(typ_d), .illegal_out(ill_d));

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  typ;
        logic [31:0] e32;
        logic [63:0] e64;
        logic [2:0]  ad_typ;
        logic [31:0] ad_imm;
        logic        ad_ill;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vectors();
        vecs[0]  = '{32'hFE000EE3, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'b011, 32'hFFFFFFFC, 1'b0};
        vecs[1]  = '{32'h800000B7, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 3'b100, 32'h80000000, 1'b0};
        vecs[2]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'b000, 32'hFFFFFFFF, 1'b0};
        vecs[3]  = '{32'h0020A423, 3'b010, 32'h00000008, 64'h0000000000000008, 3'b010, 32'h00000008, 1'b0};
        vecs[4]  = '{32'hFF9FF06F, 3'b101, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'b101, 32'hFFFFFFF8, 1'b0};
        vecs[5]  = '{32'h800FD073, 3'b110, 32'h0000001F, 64'h000000000000001F, 3'b110, 32'h0000001F, 1'b0};
        vecs[6]  = '{32'h80009073, 3'b000, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'b000, 32'hFFFFF800, 1'b0};
        vecs[7]  = '{32'h00402083, 3'b001, 32'h00000004, 64'h0000000000000004, 3'b001, 32'h00000004, 1'b0};
        vecs[8]  = '{32'h0000007F, 3'b000, 32'h00000000, 64'h0000000000000000, 3'b000, 32'h00000000, 1'b1};
        vecs[9]  = '{32'hFFF00093, 3'b111, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'b000, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{32'h00001097, 3'b100, 32'h00001000, 64'h0000000000001000, 3'b100, 32'h00001000, 1'b0};
        vecs[11] = '{32'h00008067, 3'b001, 32'h00000000, 64'h0000000000000000, 3'b001, 32'h00000000, 1'b0};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vld_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
        checks++; if (imm_a !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h want 0", imm_a); end
        checks++; if (typ_a !== 3'b000) begin errors++; $display("FAIL reset_type: got %b want 000", typ_a); end
        checks++; if (ill_d !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", ill_d); end
        checks++; if (imm_w !== 64'h0) begin errors++; $display("FAIL reset_imm64: got %h want 0", imm_w); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_decode();
        for (int i = 0; i < 12; i++) begin
            instr = vecs[i].instr;
            imm_type = vecs[i].typ;
            in_valid = 1'b1;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d]: got %b want 1", i, vld_a); end
            checks++; if (imm_a !== vecs[i].e32) begin errors++; $display("FAIL dec_imm32[%0d]: got %h want %h", i, imm_a, vecs[i].e32); end
            if (vecs[i].typ != 3'b111) begin
                checks++; if (typ_a !== vecs[i].typ) begin errors++; $display("FAIL dec_type[%0d]: got %b want %b", i, typ_a, vecs[i].typ); end
            end
            checks++; if (ill_a !== 1'b0) begin errors++; $display("FAIL dec_illegal_manual[%0d]: got %b want 0", i, ill_a); end
            checks++; if (imm_w !== vecs[i].e64) begin errors++; $display("FAIL dec_imm64[%0d]: got %h want %h", i, imm_w, vecs[i].e64); end
            checks++; if (imm_d !== vecs[i].ad_imm) begin errors++; $display("FAIL dec_auto_imm[%0d]: got %h want %h", i, imm_d, vecs[i].ad_imm); end
            checks++; if (typ_d !== vecs[i].ad_typ) begin errors++; $display("FAIL dec_auto_type[%0d]: got %b want %b", i, typ_d, vecs[i].ad_typ); end
            checks++; if (ill_d !== vecs[i].ad_ill) begin errors++; $display("FAIL dec_auto_illegal[%0d]: got %b want %b", i, ill_d, vecs[i].ad_ill); end
            step();
            checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL dec_drain[%0d]: got %b want 0", i, vld_a); end
        end
    endtask

    task automatic test_throughput();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = vecs[i].instr;
            imm_type = vecs[i].typ;
            step();
            checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL thr_ready[%0d]: got %b want 1", i, rdy_a); end
            checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL thr_valid[%0d]: got %b want 1", i, vld_a); end
            checks++; if (imm_a !== vecs[i].e32) begin errors++; $display("FAIL thr_imm[%0d]: got %h want %h", i, imm_a, vecs[i].e32); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL thr_empty: got %b want 0", vld_a); end
        checks++; if (imm_a !== vecs[3].e32) begin errors++; $display("FAIL thr_hold: got %h want %h", imm_a, vecs[3].e32); end
    endtask

    task automatic test_empty_pop();
        out_ready = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b want 0", vld_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b want 1", rdy_a); end
        out_ready = 1'b0;
        instr = vecs[4].instr;
        imm_type = vecs[4].typ;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL empty_count1_ready: got %b want 1", rdy_a); end
        checks++; if (imm_a !== vecs[4].e32) begin errors++; $display("FAIL empty_push_imm: got %h want %h", imm_a, vecs[4].e32); end
        out_ready = 1'b1;
        step();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL empty_after_pop: got %b want 0", vld_a); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = vecs[i].instr;
            imm_type = vecs[i].typ;
            step();
            checks++; if (rdy_a !== (i == 0)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, rdy_a, (i == 0)); end
            checks++; if (imm_a !== vecs[0].e32) begin errors++; $display("FAIL b2b_head[%0d]: got %h want %h", i, imm_a, vecs[0].e32); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL b2b_pop1_valid: got %b want 1", vld_a); end
        checks++; if (imm_a !== vecs[1].e32) begin errors++; $display("FAIL b2b_pop1_imm: got %h want %h", imm_a, vecs[1].e32); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL b2b_pop1_ready: got %b want 1", rdy_a); end
        step();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL b2b_third_dropped: got %b want 0", vld_a); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr = vecs[i].instr;
            imm_type = vecs[i].typ;
            step();
        end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL flush_full: got %b want 0", rdy_a); end
        flush = 1'b1;
        out_ready = 1'b1;
        instr = vecs[2].instr;
        imm_type = vecs[2].typ;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", vld_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", rdy_a); end
        step();
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL flush_nothing_stored: got %b want 0", vld_a); end
        instr = vecs[4].instr;
        imm_type = vecs[4].typ;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (imm_a !== vecs[4].e32) begin errors++; $display("FAIL flush_repush: got %h want %h", imm_a, vecs[4].e32); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            instr = vecs[i].instr;
            imm_type = vecs[i].typ;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", vld_a); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", rdy_a); end
        checks++; if (imm_a !== 32'h0) begin errors++; $display("FAIL arst_imm: got %h want 0", imm_a); end
        @(negedge clk);
        rst_n = 1'b1;
        instr = vecs[5].instr;
        imm_type = vecs[5].typ;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL arst_push_valid: got %b want 1", vld_a); end
        checks++; if (imm_a !== vecs[5].e32) begin errors++; $display("FAIL arst_push_imm: got %h want %h", imm_a, vecs[5].e32); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL arst_push_ready: got %b want 1", rdy_a); end
    endtask

    initial begin
        load_vectors();
        test_reset();
        test_decode();
        test_throughput();
        test_empty_pop();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/msrv32_imm_gen_pipe.md
MSRV32_IMM_GEN_PIPE -- requirements
Module: msrv32_imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 Parameter AUTO_DECODE, default 0; 0 = type from imm_type_in, 1 = type derived from instr_in opcode.
REQ-003 ms_riscv32_mp_clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low.
REQ-005 flush_in  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid_in  input  1  instr_in/imm_type_in valid this cycle.
REQ-007 in_ready_out  output  1  block can accept an entry this cycle.
REQ-008 instr_in  input  32  full instruction word.
REQ-009 imm_type_in  input  3  immediate type select; ignored when AUTO_DECODE=1.
REQ-010 out_valid_out  output  1  head entry valid.
REQ-011 out_ready_in  input  1  consumer takes head entry this cycle.
REQ-012 imm_out  output  XLEN  head entry immediate.
REQ-013 imm_type_out  output  3  head entry resolved type.
REQ-014 illegal_out  output  1  head entry opcode has no immediate (AUTO_DECODE=1 only).

Function
REQ-015 Type encoding: 000 I, 001 I (load/JALR), 010 S, 011 B, 100 U, 101 J, 110 CSR zimm, 111 treated as I.
REQ-016 Formats: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); U = sext({instr[31:12],12'h000}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); zimm = zero-extended instr[19:15].
REQ-017 Sign extension replicates instr[31] up to bit XLEN-1; for XLEN=64 U-type bits 63:32 equal instr[31].
REQ-018 AUTO_DECODE=1 mapping: 0010011 -> 000; 0000011, 1100111 -> 001; 0100011 -> 010; 1100011 -> 011; 0110111, 0010111 -> 100; 1101111 -> 101; 1110011 with funct3[2]=1 -> 110, else 000.
REQ-019 AUTO_DECODE=1, any other opcode: entry stored with imm 0, type 000, illegal 1; AUTO_DECODE=0: illegal always 0.
REQ-020 Storage: 2-entry FIFO of {imm, type, illegal}, occupancy counter 0..2, read/write pointers wrap modulo 2.
REQ-021 Push when in_valid_in && in_ready_out; pop when out_valid_out && out_ready_in.
REQ-022 in_ready_out = (count < 2); depends only on registered state, never combinationally on out_ready_in.
REQ-023 out_valid_out = (count > 0); imm_out/imm_type_out/illegal_out driven from head entry.
REQ-024 Latency: entry pushed at edge N visible at outputs after edge N (1 cycle) when FIFO was empty.
REQ-025 Throughput: with out_ready_in held 1, one entry per cycle, in_ready_out stays 1.
REQ-026 Simultaneous push and pop at count 1: count stays 1, new entry becomes head after old pops.
REQ-027 Full (count 2): in_ready_out 0, in_valid_in ignored; pop returns count to 1 next cycle.
REQ-028 Empty with out_ready_in 1: no pop, count unchanged.
REQ-029 Stall: while out_valid_out && !out_ready_in, head outputs held stable.
REQ-030 flush_in dominates: next edge count=0, pointers=0, any same-cycle push/pop discarded.
REQ-031 Output data when count=0: last head values held (don't care to consumer).

Reset
REQ-032 Reset low asynchronously: count 0, pointers 0, out_valid_out 0, in_ready_out 1, imm_out 0, imm_type_out 000, illegal_out 0.
REQ-033 Reset asserted mid-transfer discards all entries; first push after release behaves as from empty.
REQ-034 Storage array need not be reset; outputs forced to reset values while count=0 after reset.

Verification
REQ-035 AUTO_DECODE=0, XLEN=32, type 011, instr 32'h FE000EE3, out_ready 1 -> next cycle imm_out 32'hFFFFFFFC, type 011, valid 1.
REQ-036 XLEN=64, type 100, instr 32'h800000B7 -> imm_out 64'hFFFFFFFF80000000.
REQ-037 AUTO_DECODE=1, instr 32'h0000007F (opcode 1111111) -> illegal_out 1, imm_out 0, type 000.
REQ-038 out_ready 0, push 3 back-to-back -> in_ready 0 after 2nd push, 3rd not accepted, outputs hold 1st entry; then out_ready 1 -> entries popped in order.
REQ-039 count 2, assert flush_in with in_valid 1 -> next cycle out_valid 0, in_ready 1, nothing stored.
REQ-040 Reset low while count 2 -> out_valid 0 immediately (no clock edge), in_ready 1; after release, single push appears after 1 cycle.
